// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, parallel load, shift, rotate,
// and a self-timed LSB-first serialiser with a busy/done handshake.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] Din,
  input  logic             sin,
  output logic [WIDTH-1:0] Dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_SHL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_SER   = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // State register; reset aborts any serialisation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath; done defaults low so it never outlives one edge.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          case (mode)
            MODE_HOLD: dout_d = dout_q;
            MODE_LOAD: dout_d = Din;
            MODE_SHR:  dout_d = {sin, dout_q[WIDTH-1:1]};
            MODE_SHL:  dout_d = {dout_q[WIDTH-2:0], sin};
            MODE_ROR:  dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
            MODE_ROL:  dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
            MODE_SER: begin
              dout_d  = Din;
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = ST_SHIFT;
            end
            default:   dout_d = dout_q;
          endcase
        end
      end
      ST_SHIFT: begin
        if (en) begin
          dout_d = {1'b0, dout_q[WIDTH-1:1]};
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Dout = dout_q;
  assign sout = dout_q[0];
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=4.
module tb_universal_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [3:0] Din;
  logic       sin;
  logic [3:0] Dout;
  logic       sout;
  logic       busy;
  logic       done;

  int nvec = 0;
  int nerr = 0;

  universal_shift_reg #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .Din  (Din),
    .sin  (sin),
    .Dout (Dout),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  // Negedges at 5,15,... and posedges at 10,20,...
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b1;
    mode = 3'b001;
    Din  = 4'b1010;
    sin  = 1'b0;

    #1;
    check("rst_dout_t1", Dout, 4'b0000);
    check("rst_busy_t1", 4'(busy), 4'd0);
    check("rst_done_t1", 4'(done), 4'd0);
    #11;
    check("rst_dout_t12", Dout, 4'b0000);
    check("rst_busy_t12", 4'(busy), 4'd0);
    check("rst_done_t12", 4'(done), 4'd0);
    #3;
    rst = 1'b1;
    tick();
    check("load_1010", Dout, 4'b1010);

    mode = 3'b010; sin = 1'b1;
    tick(); check("shr_1", Dout, 4'b1101);
    tick(); check("shr_2", Dout, 4'b1110);
    mode = 3'b011; sin = 1'b0;
    tick(); check("shl_1", Dout, 4'b1100);

    mode = 3'b001; Din = 4'b1001;
    tick(); check("load_1001", Dout, 4'b1001);
    mode = 3'b100;
    tick(); check("ror_1", Dout, 4'b1100);
    mode = 3'b101;
    tick(); check("rol_1", Dout, 4'b1001);
    tick(); check("rol_2", Dout, 4'b0011);

    // Serialise 1011 with a parallel load attempted mid-stream.
    mode = 3'b110; Din = 4'b1011;
    tick();
    check("ser1_sout0", 4'(sout), 4'd1);
    check("ser1_busy0", 4'(busy), 4'd1);
    check("ser1_done0", 4'(done), 4'd0);
    mode = 3'b001; Din = 4'b1111;
    tick();
    check("ser1_sout1", 4'(sout), 4'd1);
    check("ser1_busy1", 4'(busy), 4'd1);
    tick();
    check("ser1_sout2", 4'(sout), 4'd0);
    check("ser1_busy2", 4'(busy), 4'd1);
    tick();
    check("ser1_sout3", 4'(sout), 4'd1);
    check("ser1_busy3", 4'(busy), 4'd1);
    check("ser1_done3", 4'(done), 4'd0);
    tick();
    check("ser1_end_busy", 4'(busy), 4'd0);
    check("ser1_end_done", 4'(done), 4'd1);
    check("ser1_end_dout", Dout, 4'b0000);
    mode = 3'b000;
    tick();
    check("ser1_done_clr", 4'(done), 4'd0);
    check("ser1_dout_hold", Dout, 4'b0000);

    // Serialise 0110 with a two-cycle stall after the second bit.
    mode = 3'b110; Din = 4'b0110;
    tick();
    check("ser2_sout0", 4'(sout), 4'd0);
    check("ser2_busy0", 4'(busy), 4'd1);
    mode = 3'b000;
    tick();
    check("ser2_sout1", 4'(sout), 4'd1);
    en = 1'b0;
    tick();
    check("ser2_stall1_sout", 4'(sout), 4'd1);
    check("ser2_stall1_busy", 4'(busy), 4'd1);
    check("ser2_stall1_done", 4'(done), 4'd0);
    tick();
    check("ser2_stall2_sout", 4'(sout), 4'd1);
    check("ser2_stall2_busy", 4'(busy), 4'd1);
    en = 1'b1;
    tick();
    check("ser2_sout2", 4'(sout), 4'd1);
    check("ser2_busy4", 4'(busy), 4'd1);
    tick();
    check("ser2_sout3", 4'(sout), 4'd0);
    check("ser2_busy5", 4'(busy), 4'd1);
    check("ser2_done5", 4'(done), 4'd0);
    tick();
    check("ser2_end_busy", 4'(busy), 4'd0);
    check("ser2_end_done", 4'(done), 4'd1);
    check("ser2_end_dout", Dout, 4'b0000);
    en = 1'b0;
    tick();
    check("ser2_done_clr_en0", 4'(done), 4'd0);
    en = 1'b1;

    // Serialise 1111 and abort with reset after two bits.
    mode = 3'b110; Din = 4'b1111;
    tick();
    check("ser3_sout0", 4'(sout), 4'd1);
    check("ser3_busy0", 4'(busy), 4'd1);
    mode = 3'b000;
    tick();
    check("ser3_sout1", 4'(sout), 4'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_dout", Dout, 4'b0000);
    check("abort_busy", 4'(busy), 4'd0);
    check("abort_done", 4'(done), 4'd0);
    tick();
    check("abort_hold_busy", 4'(busy), 4'd0);
    check("abort_hold_done", 4'(done), 4'd0);
    @(negedge clk);
    rst = 1'b1; mode = 3'b001; Din = 4'b0101;
    tick();
    check("post_abort_load", Dout, 4'b0101);
    check("post_abort_busy", 4'(busy), 4'd0);
    check("post_abort_done", 4'(done), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
